bin2bcd_seq: RTL

//  - Sequential shift-add-3 (double-dabble) converter from unsigned binary to 4-digit packed BCD.
//  - Sits directly upstream of smg_interface; its Number_Sig output drives smg_interface.Number_Sig.
//  - Converts a counter or measurement value into the digit codes scanned onto the 4-digit 7-segment display.

---
 rtl/smg_defs.sv | 12 +
 rtl/bcd_adj3.sv | 13 +
 rtl/bin2bcd_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/smg_defs.sv
// Constants shared by bin2bcd_seq and smg_interface: digit geometry and converter FSM encodings.
package smg_defs;

    localparam int unsigned SMG_DIGITS = 4;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_W      = SMG_DIGITS * BCD_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_adj3
    import smg_defs::*;
(
    input  logic [BCD_W-1:0] in_i,
    output logic [BCD_W-1:0] out_o
);

    always_comb begin
        out_o = (in_i >= BCD_W'(5)) ? in_i + BCD_W'(3) : in_i;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit packed BCD converter, one input bit per cycle.
// Define BIN2BCD_SAT_EN to saturate the display at 9999 when the value overflows.
module bin2bcd_seq
    import smg_defs::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [BIN_W-1:0] Bin_Data,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [NUM_W-1:0] Number_Sig,
    output logic             Ovf
);

    localparam int unsigned ACC_DIGITS = SMG_DIGITS + 1;
    localparam int unsigned ACC_W      = ACC_DIGITS * BCD_W;
    localparam int unsigned CNT_W      = $clog2(BIN_W + 1);

    logic [1:0]         state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [ACC_W-1:0]   bcd_adj;
    logic [ACC_W+BIN_W-1:0] shifted;
    logic               acc_ovf;

    for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_adj
        bcd_adj3 u_adj (
            .in_i  (bcd_q[g*BCD_W +: BCD_W]),
            .out_o (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    assign shifted = {bcd_adj, bin_q} << 1;
    assign acc_ovf = |bcd_q[ACC_W-1:NUM_W];

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        num_d   = num_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    bin_d   = Bin_Data;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = shifted[ACC_W+BIN_W-1:BIN_W];
                bin_d = shifted[BIN_W-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // The whole display word is swapped in one edge so the scanner never sees a mix.
`ifdef BIN2BCD_SAT_EN
                num_d = acc_ovf ? {SMG_DIGITS{4'h9}} : bcd_q[NUM_W-1:0];
`else
                num_d = bcd_q[NUM_W-1:0];
`endif
                ovf_d   = acc_ovf;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            num_q   <= num_d;
        end
    end

    assign Busy       = (state_q != ST_IDLE);
    assign Done       = done_q;
    assign Number_Sig = num_q;
    assign Ovf        = ovf_q;

endmodule
